// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential restoring
//                divider: FSM state encoding, default operand width and the
//                step-counter width helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Default operand width.
    localparam int DIV_N = 8;

    // A counter has to reach N-1; a single-step divider still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_N);

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder, compares against
//                the divisor at N+1 bits and subtracts when it fits.
//  Ports       : r_i        partial remainder in (always < divisor)
//                bit_i      next dividend bit shifted in
//                divisor_i  divisor
//                r_o        partial remainder out
//                qbit_o     quotient bit produced by this step
//  Revision    : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] r_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] r_o,
    output logic         qbit_o
);

    // The trial value is one bit wider than the remainder so the bit shifted
    // out of r_i takes part in the compare instead of being dropped.
    logic [N:0] w_t;
    logic [N:0] w_div_ext;

    assign w_t       = {r_i, bit_i};
    assign w_div_ext = {1'b0, divisor_i};
    assign qbit_o    = (w_t >= w_div_ext);

    // Either branch is strictly below the divisor, so N bits always hold it.
    always_comb begin
        r_o = w_t[N-1:0];
        if (qbit_o) begin
            r_o = N'(w_t - w_div_ext);
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_restoring_div.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_div
//  Description : Iterative unsigned restoring divider. Divides a 2N-bit
//                dividend by an N-bit divisor in N clocks using a start/ready
//                request and a one-cycle done pulse. Divide-by-zero and
//                quotient overflow finish immediately with flags set.
//  Ports       : clk       clock, rising edge
//                rst       synchronous active-high reset
//                start     request, accepted when start && ready
//                dividend  2N-bit dividend, sampled on accept
//                divisor   N-bit divisor, sampled on accept
//                ready     can accept a request this cycle
//                done      one-cycle completion pulse
//                quot      quotient, held until next completion
//                rem       remainder, held until next completion
//                dbz       divide-by-zero flag
//                ovf       quotient overflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module seq_restoring_div
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           ready,
    output logic           done,
    output logic [N-1:0]   quot,
    output logic [N-1:0]   rem,
    output logic           dbz,
    output logic           ovf
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [N-1:0]  r_q,     r_d;      // partial remainder
    logic [N-1:0]  q_q,     q_d;      // dividend low half / quotient shift reg
    logic [N-1:0]  div_q,   div_d;    // captured divisor
    logic [N-1:0]  quot_q,  quot_d;
    logic [N-1:0]  rem_q,   rem_d;
    logic          dbz_q,   dbz_d;
    logic          ovf_q,   ovf_d;

    logic [N-1:0]  w_r_next;
    logic          w_qbit;
    logic [N-1:0]  w_q_next;
    logic [N-1:0]  w_hi;

    div_step #(
        .N (N)
    ) u_step (
        .r_i       (r_q),
        .bit_i     (q_q[N-1]),
        .divisor_i (div_q),
        .r_o       (w_r_next),
        .qbit_o    (w_qbit)
    );

    // Dividend bits leave at the top of q_q while quotient bits enter at the
    // bottom, so after N steps q_q holds the full quotient.
    assign w_q_next = {q_q[N-2:0], w_qbit};
    assign w_hi     = dividend[2*N-1:N];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    div_d = divisor;
                    r_d   = w_hi;
                    q_d   = dividend[N-1:0];
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                    end else if (w_hi >= divisor) begin
                        // Quotient would need more than N bits.
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                r_d   = w_r_next;
                q_d   = w_q_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    quot_d  = w_q_next;
                    rem_d   = w_r_next;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign quot  = quot_q;
    assign rem   = rem_q;
    assign dbz   = dbz_q;
    assign ovf   = ovf_q;

endmodule : seq_restoring_div
`default_nettype wire

// File: tb/tb_seq_restoring_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_restoring_div
//  Description : Self-checking bench for seq_restoring_div (N=8): directed
//                table, reset abort, start held high, and random products
//                checked against plain integer division.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_restoring_div;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           ready;
    logic           done;
    logic [N-1:0]   quot;
    logic [N-1:0]   rem;
    logic           dbz;
    logic           ovf;

    int n_vec;
    int n_err;

    seq_restoring_div #(
        .N (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .dbz      (dbz),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  eq;
        logic [7:0]  er;
        logic        ez;
        logic        eo;
        int          elat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Issue one request, count edges from the accepting edge until done,
    // return the results seen while done is high, then confirm done drops.
    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic z, output logic o, output int lat);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
        q = quot;
        r = rem;
        z = dbz;
        o = ovf;
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    // Reference: plain unsigned division with the error rules applied.
    task automatic model(input logic [15:0] dd, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic z, output logic o);
        int unsigned a;
        int unsigned b;
        a = dd;
        b = dv;
        z = 1'b0;
        o = 1'b0;
        if (b == 0) begin
            z = 1'b1; q = 8'hFF; r = 8'h00;
        end else if (a / b > 255) begin
            o = 1'b1; q = 8'hFF; r = 8'h00;
        end else begin
            q = 8'(a / b);
            r = 8'(a % b);
        end
    endtask

    initial begin
        vec_t        tbl[$];
        logic [7:0]  gq, gr;
        logic        gz, go;
        int          lat;
        int          seen;

        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done",  {31'd0, done},  32'd0);
        check("reset_quot",  {24'd0, quot},  32'd0);
        check("reset_rem",   {24'd0, rem},   32'd0);
        check("reset_flags", {30'd0, dbz, ovf}, 32'd0);

        // ---------------- directed table ----------------
        tbl.push_back('{16'd65025, 8'd255, 8'd255, 8'd0,   1'b0, 1'b0, 8});
        tbl.push_back('{16'd1000,  8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 8});
        tbl.push_back('{16'd0,     8'd3,   8'd0,   8'd0,   1'b0, 1'b0, 8});
        tbl.push_back('{16'd100,   8'd0,   8'd255, 8'd0,   1'b1, 1'b0, 0});
        tbl.push_back('{16'd1280,  8'd5,   8'd255, 8'd0,   1'b0, 1'b1, 0});
        tbl.push_back('{16'd65535, 8'd255, 8'd255, 8'd0,   1'b0, 1'b1, 0});
        tbl.push_back('{16'd65024, 8'd255, 8'd254, 8'd254, 1'b0, 1'b0, 8});
        tbl.push_back('{16'd256,   8'd1,   8'd255, 8'd0,   1'b0, 1'b1, 0});
        tbl.push_back('{16'd1,     8'd1,   8'd1,   8'd0,   1'b0, 1'b0, 8});
        tbl.push_back('{16'd255,   8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 8});

        foreach (tbl[i]) begin
            run_op(tbl[i].dd, tbl[i].dv, gq, gr, gz, go, lat);
            check("tbl_latency", lat, tbl[i].elat);
            check("tbl_quot", {24'd0, gq}, {24'd0, tbl[i].eq});
            check("tbl_rem",  {24'd0, gr}, {24'd0, tbl[i].er});
            check("tbl_dbz",  {31'd0, gz}, {31'd0, tbl[i].ez});
            check("tbl_ovf",  {31'd0, go}, {31'd0, tbl[i].eo});
        end

        // ---------------- reset during CALC ----------------
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_done",  {31'd0, done},  32'd0);
        check("abort_quot",  {24'd0, quot},  32'd0);
        check("abort_rem",   {24'd0, rem},   32'd0);
        check("abort_flags", {30'd0, dbz, ovf}, 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        run_op(16'd1000, 8'd7, gq, gr, gz, go, lat);
        check("after_abort_lat",  lat, 8);
        check("after_abort_quot", {24'd0, gq}, 32'd142);
        check("after_abort_rem",  {24'd0, gr}, 32'd6);

        // ---------------- start held high ----------------
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 16'd65025;   // must be ignored during CALC
        divisor  = 8'd255;
        check("busy_ready", {31'd0, ready}, 32'd0);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_lat1",  lat, 8);
        check("held_quot1", {24'd0, quot}, 32'd142);
        check("held_rem1",  {24'd0, rem},  32'd6);
        check("held_ready_done", {31'd0, ready}, 32'd1);
        @(posedge clk);         // second request accepted here
        #1;
        start = 1'b0;
        check("held_b2b_done", {31'd0, done}, 32'd0);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_lat2",  lat, 8);
        check("held_quot2", {24'd0, quot}, 32'd255);
        check("held_rem2",  {24'd0, rem},  32'd0);
        @(posedge clk);
        #1;

        // ---------------- random products ----------------
        for (int k = 0; k < 100; k++) begin
            logic [7:0]  a, b, r;
            logic [15:0] dd;
            logic [7:0]  mq, mr;
            logic        mz, mo;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            r = (k < 50) ? 8'd0 : 8'($urandom_range(0, int'(b) - 1));
            dd = 16'(int'(a) * int'(b) + int'(r));
            model(dd, b, mq, mr, mz, mo);
            run_op(dd, b, gq, gr, gz, go, lat);
            check("rnd_model_q", {24'd0, mq}, {24'd0, a});
            check("rnd_quot", {24'd0, gq}, {24'd0, a});
            check("rnd_rem",  {24'd0, gr}, {24'd0, r});
            check("rnd_flags", {30'd0, gz, go}, {30'd0, mz, mo});
            check("rnd_lat",  lat, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_restoring_div
`default_nettype wire
